multiword_add_sequencer: RTL
============================

Name: multiword_add_sequencer

Overview:
- Multi-precision add/subtract sequencer. Accepts wide operands (N*WORDS bits) over a valid/ready handshake.
- Drives one shared N-bit carry-select adder instance word by word, least-significant word first, and chains the carry through a register.
- Sits between the operand source and the result consumer. Trades latency (WORDS cycles) for a single narrow adder.

Parameters:
- N, 8, width of one word, i.e. the width of the internal carry_select_adder.
- WORDS, 4, number of words per operand (>=1); total operand width W = N*WORDS.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  sequencer can accept operands
- A  input  W  operand A
- B  input  W  operand B
- Cin  input  1  carry-in (add) / borrow-in (sub)
- Sub  input  1  0 = A+B+Cin, 1 = A-B-Cin
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- Sum  output  W  result
- Cout  output  1  final carry-out (add) / not-borrow (sub)
- Overflow  output  1  signed two's-complement overflow of the W-bit result
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - Sum=0, Cout=0, Overflow=0; word index=0; carry register=0.
  - Reset has priority over every other event, including mid-RUN and mid-DONE; an in-flight operation is discarded with no output.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch A into opA;
    - latch B into opB (B stored bit-inverted when Sub=1);
    - carry register <= Cin ^ Sub;
    - index <= 0;
    - save Sub;
    - go to RUN.
  - Sum/Cout/Overflow keep their previous values until overwritten.
- RUN:
  - in_ready=0.
  - Each cycle, the adder is fed word k of opA/opB (bits k*N+N-1 : k*N) plus the carry register.
  - At the edge: Sum word k <= adder Sum; carry register <= adder Cout; k <= k+1.
  - On the edge that writes word WORDS-1:
    - Cout <= adder Cout;
    - Overflow <= (opA[W-1] == opB[W-1]) && (result MSB != opA[W-1]), using the stored (possibly inverted) opB;
    - go to DONE.
- Latency: with the acceptance edge at t, out_valid is high after edge t+WORDS (exactly WORDS RUN cycles). WORDS=1 gives a single RUN cycle.
- DONE:
  - out_valid=1.
  - Sum/Cout/Overflow held stable while out_ready=0; no bound on stall length.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. Result registers retain their values.
- in_ready is high only in IDLE. No overlap of a new acceptance with a pending result; in_valid in RUN/DONE is ignored.
- Back-to-back throughput: one operation per WORDS+2 cycles (accept, WORDS RUN, handshake).
- Subtract semantics:
  - Sub=1 computes A + ~B + ~Cin, i.e. A-B-Cin mod 2^W.
  - Cout=1 means no borrow.
- Sum bits not yet written during RUN hold stale values; consumers may only sample when out_valid=1.
- Modular arithmetic: wrap-around mod 2^W with no saturation.

Test Plan:
- N=8, WORDS=4: A=0x0000_0001, B=0xFFFF_FFFF, Cin=0, Sub=0, out_ready=1 -> out_valid rises 4 cycles after the acceptance edge; Sum=0x0000_0000, Cout=1, Overflow=0.
- Sub=1, A=0x0000_0005, B=0x0000_0007, Cin=0 -> Sum=0xFFFF_FFFE, Cout=0 (borrow), Overflow=0. Then A=0x0000_0007, B=0x0000_0005, Cin=1 -> Sum=0x0000_0001, Cout=1.
- A=0x7FFF_FFFF, B=0x0000_0001, Sub=0 -> Sum=0x8000_0000, Overflow=1, Cout=0. A=0x8000_0000, B=0x8000_0000 -> Sum=0, Cout=1, Overflow=1.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while toggling in_valid and the A/B/Cin/Sub inputs -> Sum/Cout/Overflow unchanged, in_ready=0, no second acceptance; out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two queued operations, out_ready=1 -> acceptances exactly 6 cycles apart (WORDS+2); both results correct.
- Reset mid-RUN: assert rst during the 2nd RUN cycle -> after that edge out_valid=0, in_ready=1, Sum=0, Cout=0, busy=0; the next operation completes correctly with no carry leakage.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract sequencer: W-bit operands are processed one N-bit word per
// cycle, LS word first, through a single carry-select adder with a registered carry chain.
module multiword_add_sequencer #(
   parameter int unsigned N     = 8,
   parameter int unsigned WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*WORDS-1:0]   A,
   input  logic [N*WORDS-1:0]   B,
   input  logic                 Cin,
   input  logic                 Sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [N*WORDS-1:0]   Sum,
   output logic                 Cout,
   output logic                 Overflow,
   output logic                 busy
);

   localparam int unsigned W     = N * WORDS;
   localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned LO    = (N + 1) / 2;
   localparam int unsigned HI    = N - LO;
   localparam int unsigned LO1   = LO + 1;
   localparam int unsigned HI1   = HI + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [W-1:0]     op_a;
   logic [W-1:0]     op_b;
   logic             carry_q;
   logic [IDX_W-1:0] idx_q;

   logic [N-1:0]     word_a;
   logic [N-1:0]     word_b;
   logic [N-1:0]     add_sum;
   logic             add_cout;
   logic             last_word;

   assign word_a    = op_a[idx_q*N +: N];
   assign word_b    = op_b[idx_q*N +: N];
   assign last_word = (idx_q == LAST_IDX);

   // Shared N-bit carry-select adder: low half ripples, high half is precomputed
   // for both carries and selected by the low-half carry-out.
   generate
      if (HI == 0) begin : g_csa_narrow
         logic [LO:0] lo_res;
         assign lo_res   = {1'b0, word_a[LO-1:0]} + {1'b0, word_b[LO-1:0]} + LO1'(carry_q);
         assign add_sum  = lo_res[LO-1:0];
         assign add_cout = lo_res[LO];
      end else begin : g_csa_split
         logic [LO:0] lo_res;
         logic [HI:0] hi_c0;
         logic [HI:0] hi_c1;
         assign lo_res   = {1'b0, word_a[LO-1:0]} + {1'b0, word_b[LO-1:0]} + LO1'(carry_q);
         assign hi_c0    = {1'b0, word_a[N-1:LO]} + {1'b0, word_b[N-1:LO]};
         assign hi_c1    = {1'b0, word_a[N-1:LO]} + {1'b0, word_b[N-1:LO]} + HI1'(1'b1);
         assign add_sum  = {(lo_res[LO] ? hi_c1[HI-1:0] : hi_c0[HI-1:0]), lo_res[LO-1:0]};
         assign add_cout = lo_res[LO] ? hi_c1[HI] : hi_c0[HI];
      end
   endgenerate

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (in_valid)  state_d = RUN;
         RUN:  if (last_word) state_d = DONE;
         DONE: if (out_ready) state_d = IDLE;
         default:             state_d = IDLE;
      endcase
   end

   // State, handshake flags and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         carry_q   <= 1'b0;
         idx_q     <= '0;
         Sum       <= '0;
         Cout      <= 1'b0;
         Overflow  <= 1'b0;
      end else begin
         state_q   <= state_d;
         in_ready  <= (state_d == IDLE);
         out_valid <= (state_d == DONE);
         busy      <= (state_d != IDLE);
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_a    <= A;
                  op_b    <= Sub ? ~B : B;
                  carry_q <= Cin ^ Sub;
                  idx_q   <= '0;
               end
            end
            RUN: begin
               Sum[idx_q*N +: N] <= add_sum;
               carry_q           <= add_cout;
               idx_q             <= idx_q + IDX_W'(1);
               if (last_word) begin
                  Cout     <= add_cout;
                  Overflow <= (op_a[W-1] == op_b[W-1]) && (add_sum[N-1] != op_a[W-1]);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
